ram_reader: RTL and testbench
=============================

RAM_READER -- requirements
Module: ram_reader

Interface
REQ-001 Parameter: SEED, default 8'h00, base of the expected pattern; expected word at address i is SEED + i, modulo 256.
REQ-002 Port: clk  input  1  single clock; all flops rise-edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 Port: start  input  1  readback request; sampled only in IDLE.
REQ-005 Port: add  output  3  RAM read address.
REQ-006 Port: rd  output  1  RAM read strobe.
REQ-007 Port: rdata  input  8  RAM read data, valid exactly one cycle after rd is high (synchronous read, latency 1).
REQ-008 Port: out_data  output  8  word read back, registered.
REQ-009 Port: out_valid  output  1  out_data is valid.
REQ-010 Port: out_ready  input  1  downstream accept; a transfer occurs on an edge where out_valid=1 and out_ready=1.
REQ-011 Port: sum  output  11  unsigned sum of the words read in the current or last pass.
REQ-012 Port: err_cnt  output  4  count of words not equal to the expected value.
REQ-013 Port: busy  output  1  high in every state except IDLE.
REQ-014 Port: done  output  1  one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have the states IDLE, ISSUE, CAPTURE, OUT and DONE, with a 3-bit index idx from 0 to 7.
REQ-016 In IDLE, start=1 at an edge SHALL move the FSM to ISSUE, clear idx, sum and err_cnt, and set add=0.
REQ-017 In ISSUE, rd SHALL be 1 and add SHALL equal idx; the FSM then goes to CAPTURE unconditionally.
REQ-018 rd SHALL be 0 in every state other than ISSUE, and add SHALL hold its value outside ISSUE.
REQ-019 In CAPTURE, the edge leaving the state SHALL:
- latch rdata into out_data;
- add zero-extended rdata to sum;
- increment err_cnt if rdata != SEED+idx;
- go to OUT.
REQ-020 In OUT, out_valid SHALL be 1, and out_data SHALL stay stable until a transfer.
REQ-021 On a transfer in OUT: if idx=7, go to DONE; otherwise increment idx and go to ISSUE.
REQ-022 out_valid SHALL be 0 in every state except OUT.
REQ-023 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-024 With out_ready held at 1, each word SHALL take 3 cycles, and done SHALL be high in the 25th cycle after the start-accepting edge.
REQ-025 start SHALL be ignored while busy=1; there is no queuing and no restart.
REQ-026 sum SHALL not overflow (8 x 255 = 2040 < 2048), and err_cnt SHALL saturate at no value below 8.
REQ-027 sum and err_cnt SHALL hold their final values after DONE until the next accepted start.
REQ-028 out_valid, once asserted, SHALL not drop before a transfer.
REQ-029 out_ready SHALL have no effect outside OUT.
REQ-030 idx SHALL never wrap from 7 to 0 within a pass.

Reset
REQ-031 While rst=0, the block SHALL asynchronously force the FSM to IDLE and set:
- idx=0, add=0, rd=0;
- out_data=0, out_valid=0;
- sum=0, err_cnt=0;
- busy=0, done=0.
REQ-032 Reset asserted mid-pass SHALL abort the pass with no done pulse.
REQ-033 After rst returns to 1, the block SHALL accept start on the first edge that samples start=1.

Verification
REQ-034 SEED=0, RAM[i]=i, out_ready=1, start pulse -> out_data 0..7 in order, sum=28, err_cnt=0, done high in the 25th cycle.
REQ-035 As REQ-034, with out_ready low for 5 cycles while word 3 is presented -> out_data=3 held stable and out_valid held at 1, done in the 30th cycle, totals unchanged.
REQ-036 RAM[5]=8'hFF, otherwise as REQ-034 -> err_cnt=1, sum=278.
REQ-037 All RAM words 8'hFF, SEED=0 -> sum=2040, err_cnt=8, no overflow.
REQ-038 rst=0 during word 4, then released, then start -> all outputs 0 during reset, no done pulse; the new pass completes exactly as in REQ-034.
REQ-039 start re-pulsed during word 2 -> ignored; a single pass with a single done pulse.

Source files
------------

// File: rtl/ram_reader.sv
// Reads eight words from a synchronous-read RAM, streams each one out over a
// valid/ready port, and accumulates their sum and a count of pattern mismatches.
module ram_reader #(
    parameter logic [7:0] SEED = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [2:0]  add,
    output logic        rd,
    input  logic [7:0]  rdata,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [10:0] sum,
    output logic [3:0]  err_cnt,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        OUT,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [2:0]  add_q, add_d;
    logic [7:0]  out_data_q, out_data_d;
    logic [10:0] sum_q, sum_d;
    logic [3:0]  err_cnt_q, err_cnt_d;
    logic [7:0]  exp_word;

    assign exp_word = SEED + {5'b0, idx_q};

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d    = state_q;
        idx_d      = idx_q;
        add_d      = add_q;
        out_data_d = out_data_q;
        sum_d      = sum_q;
        err_cnt_d  = err_cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ISSUE;
                    idx_d     = 3'd0;
                    add_d     = 3'd0;
                    sum_d     = 11'd0;
                    err_cnt_d = 4'd0;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                // rdata answers the strobe issued in the previous cycle
                out_data_d = rdata;
                sum_d      = sum_q + {3'b000, rdata};
                if (rdata != exp_word && err_cnt_q != 4'hF) begin
                    err_cnt_d = err_cnt_q + 4'd1;
                end
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    if (idx_q == 3'd7) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        add_d   = idx_q + 3'd1;
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            add_q      <= 3'd0;
            out_data_q <= 8'd0;
            sum_q      <= 11'd0;
            err_cnt_q  <= 4'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            add_q      <= add_d;
            out_data_q <= out_data_d;
            sum_q      <= sum_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign add       = add_q;
    assign rd        = (state_q == ISSUE);
    assign out_data  = out_data_q;
    assign out_valid = (state_q == OUT);
    assign sum       = sum_q;
    assign err_cnt   = err_cnt_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_ram_reader.sv
// Scoreboard bench for ram_reader: a driver issues passes against a RAM model
// and queues expected words/totals; a negedge monitor compares DUT activity.
module tb_ram_reader;

    localparam logic [7:0] SEED = 8'h00;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  add;
    logic        rd;
    logic [7:0]  rdata;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] sum;
    logic [3:0]  err_cnt;
    logic        busy;
    logic        done;

    ram_reader #(.SEED(SEED)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .add       (add),
        .rd        (rd),
        .rdata     (rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .err_cnt   (err_cnt),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM, one cycle of latency.
    logic [7:0] mem [8];
    always @(posedge clk) if (rd) rdata <= mem[add];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard state shared between driver (producer) and monitor (consumer).
    logic [7:0] exp_q [$];
    int exp_sum = 0;
    int exp_err = 0;

    int xfer_cnt = 0;
    int rd_idx = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic       prev_valid = 1'b0;
    logic       prev_xfer = 1'b0;
    logic       prev_done = 1'b0;
    logic [7:0] prev_data = 8'd0;

    always @(negedge clk) begin
        if (!rst) begin
            check("reset_outputs", {add, rd, out_data, out_valid, sum, err_cnt, busy, done}, 64'd0);
            xfer_cnt   = 0;
            rd_idx     = 0;
            prev_valid = 1'b0;
            prev_xfer  = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (rd) begin
                check("read_addr", add, rd_idx);
                rd_idx++;
            end
            if (prev_valid && !prev_xfer) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 1'b1, 1'b0);
                end else begin
                    check("out_word", out_data, exp_q.pop_front());
                end
                xfer_cnt++;
            end
            if (prev_done) check("done_one_cycle", done, 1'b0);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("sum_at_done", sum, exp_sum);
                check("err_at_done", err_cnt, exp_err);
                check("words_left_at_done", exp_q.size(), 0);
            end
            if (!busy) begin
                xfer_cnt = 0;
                rd_idx   = 0;
            end
            prev_valid = out_valid;
            prev_xfer  = out_valid && out_ready;
            prev_data  = out_data;
            prev_done  = done;
        end
    end

    // mode: 0 ready held, 1 stall on word 3, 2 re-pulse start on word 2,
    //       3 random ready, 4 reset during word 4
    task automatic run_pass(input int mode, input int exp_cycles);
        int  base;
        int  t0;
        int  stalled;
        bit  aborted;
        stalled = 0;
        aborted = 1'b0;
        exp_sum = 0;
        exp_err = 0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(mem[i]);
            exp_sum += int'(mem[i]);
            if (mem[i] != 8'(SEED + i)) exp_err++;
        end
        base = done_cnt;
        @(posedge clk); #1;
        start     = 1'b1;
        out_ready = (mode == 3) ? ($urandom_range(0, 3) != 0) : 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0    = cyc;
        for (int c = 0; c < 400 && done_cnt == base; c++) begin
            @(posedge clk); #1;
            case (mode)
                1: begin
                    out_ready = !(out_valid && xfer_cnt == 3 && stalled < 5);
                    if (!out_ready) stalled++;
                end
                2: start = (out_valid && xfer_cnt == 2);
                3: out_ready = ($urandom_range(0, 3) != 0);
                4: if (out_valid && xfer_cnt == 4) begin
                    rst     = 1'b0;
                    aborted = 1'b1;
                    break;
                end
                default: out_ready = 1'b1;
            endcase
        end
        start     = 1'b0;
        out_ready = 1'b1;
        if (aborted) begin
            repeat (3) @(posedge clk);
            #1;
            check("abort_no_done", done_cnt - base, 0);
            rst = 1'b1;
            exp_q.delete();
        end else begin
            check("pass_done_count", done_cnt - base, 1);
            if (exp_cycles > 0) check("done_cycle", done_cyc - t0 + 1, exp_cycles);
            repeat (4) @(posedge clk);
            #1;
            check("sum_held", sum, exp_sum);
            check("err_held", err_cnt, exp_err);
            check("idle_after_done", busy, 1'b0);
            check("single_done", done_cnt - base, 1);
            exp_q.delete();
        end
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) mem[i] = 8'(SEED + i);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        run_pass(0, 25);

        run_pass(1, 30);

        mem[5] = 8'hFF;
        run_pass(0, 25);

        for (int i = 0; i < 8; i++) mem[i] = 8'hFF;
        run_pass(0, 25);

        for (int i = 0; i < 8; i++) mem[i] = 8'(SEED + i);
        run_pass(4, -1);
        run_pass(0, 25);

        run_pass(2, 25);

        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 8; i++)
                mem[i] = ($urandom_range(0, 1) != 0) ? 8'(SEED + i) : 8'($urandom);
            run_pass(3, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
